// File: rtl/uart_boot_loader.sv
// UART boot loader: deserialises 8N1 bytes from uart_rx and writes a framed,
// checksummed program image into the 16-bit program BSRAM, holding boot_mode until it is valid.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// F_IDLE    | waiting for the 0xA5 sync byte, everything else ignored
// F_LEN_HI  | expecting high byte of the word count
// F_LEN_LO  | expecting low byte of the word count, range-checked here
// F_DATA_HI | expecting high byte of the next word
// F_DATA_LO | expecting low byte; the word is written on the following clock
// F_CHK     | expecting the checksum byte
// F_DONE    | image valid, CPU released; terminal until rst
// F_ERROR   | load failed; a new 0xA5 restarts the frame
module uart_boot_loader #(
    parameter int CLK_FREQ     = 27000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_WIDTH   = 11,
    parameter int MAX_WORDS    = 2048,
    parameter int TIMEOUT_CLKS = 2700000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  mem_ce,
    output logic                  mem_wre,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_din,
    output logic                  boot_mode,
    output logic                  boot_done,
    output logic                  boot_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BT_W-1:0] BIT_RELOAD  = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [BT_W-1:0] HALF_RELOAD = BT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0] TO_RELOAD   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [15:0]     MAX_LEN     = 16'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        F_IDLE, F_LEN_HI, F_LEN_LO, F_DATA_HI, F_DATA_LO, F_CHK, F_DONE, F_ERROR
    } f_state_t;

    rx_state_t       rx_state;
    logic            rx_meta;
    logic            rx_s;
    logic [BT_W-1:0] bit_timer;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_shift;
    logic            byte_valid;
    logic            frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_timer  <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_s       <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state  <= RX_START;
                        bit_timer <= HALF_RELOAD;
                    end
                end
                RX_START: begin
                    if (bit_timer != '0) begin
                        bit_timer <= bit_timer - 1'b1;
                    end else if (!rx_s) begin
                        rx_state  <= RX_DATA;
                        bit_timer <= BIT_RELOAD;
                        bit_idx   <= '0;
                    end else begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (bit_timer != '0) begin
                        bit_timer <= bit_timer - 1'b1;
                    end else begin
                        rx_shift  <= {rx_s, rx_shift[7:1]};
                        bit_timer <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (bit_timer != '0) begin
                        bit_timer <= bit_timer - 1'b1;
                    end else begin
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    f_state_t          f_state;
    logic [7:0]        len_hi;
    logic [ADDR_WIDTH:0] len_words;
    logic [7:0]        data_hi;
    logic [7:0]        chk_acc;
    logic [TO_W-1:0]   to_timer;
    logic              frame_active;
    logic [15:0]       len_full;
    logic [ADDR_WIDTH:0] wl_next;

    assign frame_active = (f_state == F_LEN_HI) || (f_state == F_LEN_LO) ||
                          (f_state == F_DATA_HI) || (f_state == F_DATA_LO) ||
                          (f_state == F_CHK);
    assign len_full = {len_hi, rx_shift};
    assign wl_next  = words_loaded + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_state      <= F_IDLE;
            len_hi       <= '0;
            len_words    <= '0;
            data_hi      <= '0;
            chk_acc      <= '0;
            to_timer     <= TO_RELOAD;
            mem_ce       <= 1'b0;
            mem_wre      <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            boot_mode    <= 1'b1;
            boot_done    <= 1'b0;
            boot_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_ce  <= 1'b0;
            mem_wre <= 1'b0;
            if (byte_valid) begin
                to_timer <= TO_RELOAD;
            end else if (frame_active && to_timer != '0) begin
                to_timer <= to_timer - 1'b1;
            end

            if (frame_active && frame_err) begin
                f_state    <= F_ERROR;
                boot_error <= 1'b1;
            end else if (frame_active && !byte_valid && to_timer == '0) begin
                f_state    <= F_ERROR;
                boot_error <= 1'b1;
            end else if (byte_valid) begin
                case (f_state)
                    F_IDLE, F_ERROR: begin
                        if (rx_shift == 8'hA5) begin
                            f_state      <= F_LEN_HI;
                            words_loaded <= '0;
                            chk_acc      <= '0;
                            boot_error   <= 1'b0;
                        end
                    end
                    F_LEN_HI: begin
                        len_hi  <= rx_shift;
                        chk_acc <= chk_acc + rx_shift;
                        f_state <= F_LEN_LO;
                    end
                    F_LEN_LO: begin
                        chk_acc   <= chk_acc + rx_shift;
                        len_words <= len_full[ADDR_WIDTH:0];
                        if (len_full > MAX_LEN) begin
                            f_state    <= F_ERROR;
                            boot_error <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            f_state <= F_CHK;
                        end else begin
                            f_state <= F_DATA_HI;
                        end
                    end
                    F_DATA_HI: begin
                        data_hi <= rx_shift;
                        chk_acc <= chk_acc + rx_shift;
                        f_state <= F_DATA_LO;
                    end
                    F_DATA_LO: begin
                        // The write strobe lands on the clock after the low byte arrives.
                        chk_acc      <= chk_acc + rx_shift;
                        mem_ce       <= 1'b1;
                        mem_wre      <= 1'b1;
                        mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                        mem_din      <= {data_hi, rx_shift};
                        words_loaded <= wl_next;
                        f_state      <= (wl_next == len_words) ? F_CHK : F_DATA_HI;
                    end
                    F_CHK: begin
                        if (rx_shift == chk_acc) begin
                            f_state   <= F_DONE;
                            boot_mode <= 1'b0;
                            boot_done <= 1'b1;
                        end else begin
                            f_state    <= F_ERROR;
                            boot_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: serial frames driven bit by bit, BSRAM writes captured
// and compared with expectations from a frame-level model.
module tb_uart_boot_loader;

    localparam int CPB  = 16;
    localparam int AW   = 11;
    localparam int TO   = 2000;
    localparam int GAP  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic          mem_ce, mem_wre, boot_mode, boot_done, boot_error;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [AW:0]   words_loaded;

    uart_boot_loader #(
        .CLK_FREQ(64), .BAUD(4), .ADDR_WIDTH(AW), .MAX_WORDS(2048), .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_addr(mem_addr), .mem_din(mem_din),
        .boot_mode(boot_mode), .boot_done(boot_done), .boot_error(boot_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] wr_addr_q[$];
    logic [15:0]   wr_din_q[$];
    int   ce_bad = 0;
    int   dbl_wre = 0;
    logic prev_wre = 1'b0;

    always @(negedge clk) begin
        if (mem_wre === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_din_q.push_back(mem_din);
        end
        if (mem_wre !== mem_ce) ce_bad++;
        if (mem_wre === 1'b1 && prev_wre === 1'b1) dbl_wre++;
        prev_wre = mem_wre;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got no summary, want finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_wr();
        wr_addr_q.delete();
        wr_din_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_wr();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    // exp_din holds the expected words right-aligned, first word most significant.
    task automatic check_result(input string tag, input int exp_nw, input logic [63:0] exp_din,
                                input logic exp_done, input logic exp_err, input int exp_words);
        int n;
        n = wr_din_q.size();
        check({tag, ".nwr"}, n, exp_nw);
        for (int k = 0; k < exp_nw && k < n; k++) begin
            check({tag, ".addr"}, 32'(wr_addr_q[k]), k);
            check({tag, ".din"}, 32'(wr_din_q[k]), 32'(exp_din[16*(exp_nw-1-k) +: 16]));
        end
        check({tag, ".done"}, 32'(boot_done), 32'(exp_done));
        check({tag, ".err"}, 32'(boot_error), 32'(exp_err));
        check({tag, ".mode"}, 32'(boot_mode), exp_done ? 32'd0 : 32'd1);
        check({tag, ".words"}, 32'(words_loaded), exp_words);
    endtask

    typedef struct {
        int           nb;
        logic [127:0] bytes;
        int           bad_idx;
        bit           keep;
        int           exp_nw;
        logic [63:0]  exp_din;
        logic         exp_done;
        logic         exp_err;
        int           exp_words;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // CHK for the 3-word image: 00+03+12+34+56+78+9A+BC = 0x26D -> 0x6D.
        tbl[0] = '{10, 128'hA5_00_03_12_34_56_78_9A_BC_6D, -1, 1'b0, 3, 64'h1234_5678_9ABC, 1'b1, 1'b0, 3};
        tbl[1] = '{10, 128'hA5_00_03_12_34_56_78_9A_BC_6C, -1, 1'b0, 3, 64'h1234_5678_9ABC, 1'b0, 1'b1, 3};
        tbl[2] = '{10, 128'hA5_00_03_12_34_56_78_9A_BC_6D, -1, 1'b1, 3, 64'h1234_5678_9ABC, 1'b1, 1'b0, 3};
        tbl[3] = '{7,  128'h00_FF_3C_A5_00_00_00,          -1, 1'b0, 0, 64'h0,             1'b1, 1'b0, 0};
        tbl[4] = '{3,  128'hA5_08_01,                      -1, 1'b0, 0, 64'h0,             1'b0, 1'b1, 0};
        tbl[5] = '{4,  128'hA5_00_01_22,                    3, 1'b0, 0, 64'h0,             1'b0, 1'b1, 0};

        do_reset();
        check("rst.ce", 32'(mem_ce), 0);
        check("rst.wre", 32'(mem_wre), 0);
        check("rst.addr", 32'(mem_addr), 0);
        check("rst.din", 32'(mem_din), 0);
        check("rst.mode", 32'(boot_mode), 1);
        check("rst.done", 32'(boot_done), 0);
        check("rst.err", 32'(boot_error), 0);
        check("rst.words", 32'(words_loaded), 0);

        for (int t = 0; t < 6; t++) begin
            if (!tbl[t].keep) do_reset();
            clear_wr();
            for (int i = 0; i < tbl[t].nb; i++)
                send_byte(tbl[t].bytes[8*(tbl[t].nb-1-i) +: 8], i == tbl[t].bad_idx);
            repeat (4) @(negedge clk);
            check_result($sformatf("vec%0d", t), tbl[t].exp_nw, tbl[t].exp_din,
                         tbl[t].exp_done, tbl[t].exp_err, tbl[t].exp_words);
        end

        // boot_mode must fall exactly one clock after the checksum byte is accepted
        begin
            logic [79:0] fr;
            fr = 80'hA5_00_03_12_34_56_78_9A_BC_6D;
            do_reset();
            for (int i = 0; i < 9; i++) send_byte(fr[8*(9-i) +: 8], 1'b0);
            fork
                send_byte(8'h6D, 1'b0);
                begin
                    int n;
                    n = 0;
                    while (dut.byte_valid !== 1'b1 && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    check("tim.bv_seen", 32'(n < 400), 1);
                    check("tim.mode_at_bv", 32'(boot_mode), 1);
                    check("tim.done_at_bv", 32'(boot_done), 0);
                    @(negedge clk);
                    check("tim.mode_next", 32'(boot_mode), 0);
                    check("tim.done_next", 32'(boot_done), 1);
                end
            join
        end

        // a 4-clock low glitch mid-frame must not produce a byte
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h47, 1'b0);
        check_result("glitch", 1, 64'h1234, 1'b1, 1'b0, 1);

        // inter-byte timeout after one written word
        begin
            int n;
            do_reset();
            send_byte(8'hA5, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h02, 1'b0);
            send_byte(8'h11, 1'b0);
            send_byte(8'h22, 1'b0);
            check("to.err_before", 32'(boot_error), 0);
            n = 0;
            while (boot_error !== 1'b1 && n < 3 * TO) begin
                @(negedge clk);
                n++;
            end
            check("to.latency_ok", 32'(n >= TO - 60 && n <= TO + 40), 1);
            check_result("to", 1, 64'h1122, 1'b0, 1'b1, 1);
        end

        // reset while waiting for the low byte of word 1
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        check("mid.words_pre", 32'(words_loaded), 1);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid.ce", 32'(mem_ce), 0);
        check("mid.wre", 32'(mem_wre), 0);
        check("mid.addr", 32'(mem_addr), 0);
        check("mid.din", 32'(mem_din), 0);
        check("mid.mode", 32'(boot_mode), 1);
        check("mid.done", 32'(boot_done), 0);
        check("mid.err", 32'(boot_error), 0);
        check("mid.words", 32'(words_loaded), 0);
        rst = 1'b0;
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        clear_wr();
        for (int i = 0; i < tbl[0].nb; i++)
            send_byte(tbl[0].bytes[8*(tbl[0].nb-1-i) +: 8], 1'b0);
        check_result("mid.reload", 3, 64'h1234_5678_9ABC, 1'b1, 1'b0, 3);

        // randomized frames against a frame-level model
        for (int r = 0; r < 16; r++) begin
            int          nnoise, len;
            logic [7:0]  sum, hi, lo, chk, nb;
            logic [63:0] exp_din;
            bit          good;
            do_reset();
            nnoise = $urandom_range(0, 2);
            for (int i = 0; i < nnoise; i++) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb, 1'b0);
            end
            len = $urandom_range(0, 4);
            sum = 8'(len);
            exp_din = '0;
            send_byte(8'hA5, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'(len), 1'b0);
            for (int w = 0; w < len; w++) begin
                hi = 8'($urandom);
                lo = 8'($urandom);
                sum = sum + hi + lo;
                exp_din = (exp_din << 16) | 64'({hi, lo});
                send_byte(hi, 1'b0);
                send_byte(lo, 1'b0);
            end
            good = ($urandom_range(0, 3) != 0);
            chk = good ? sum : sum + 8'($urandom_range(1, 255));
            send_byte(chk, 1'b0);
            repeat (4) @(negedge clk);
            check_result($sformatf("rnd%0d", r), len, exp_din, good, !good, len);
        end

        check("strobe.ce_follows_wre", ce_bad, 0);
        check("strobe.single_cycle", dbl_wre, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
